// File: rtl/sbox_pprm_pipe.sv
// Pipelined multi-lane AES S-box (forward/inverse per transfer) with valid/ready handshakes.
// Define SBOX_PIPE_CNT_EN to add the saturating xfer_count output.
module sbox_pprm_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_encrypt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_encrypt
`ifdef SBOX_PIPE_CNT_EN
    ,
    output logic [31:0]        xfer_count
`endif
);
    localparam int W = 8 * LANES;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x240, x252;
        x2  = gf_mul(x, x);
        x3  = gf_mul(x2, x);
        x6  = gf_mul(x3, x3);
        x12 = gf_mul(x6, x6);
        x15 = gf_mul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [W-1:0] seg0_d, seg1_d, seg2_d;
    logic [W-1:0] a_d, b_d;
    logic         a_v, a_e, b_v, b_e;
    logic         rdy_in, rdy_a, rdy_b;

    always_comb begin
        // NOTE: default assignment first keeps every combinational block latch-free.
        seg0_d = in_data;
        if (!in_encrypt)
            for (int i = 0; i < LANES; i++) seg0_d[8*i +: 8] = aff_inv(in_data[8*i +: 8]);
    end

    always_comb begin
        seg1_d = '0;
        for (int i = 0; i < LANES; i++) seg1_d[8*i +: 8] = gf_inv(a_d[8*i +: 8]);
    end

    always_comb begin
        seg2_d = b_d;
        if (b_e)
            for (int i = 0; i < LANES; i++) seg2_d[8*i +: 8] = aff_fwd(b_d[8*i +: 8]);
    end

    // Each optional register is either a real stage or a transparent wire; ready ripples back.
    generate
        if (STAGES >= 2) begin : g_reg0
            always_ff @(posedge clk) begin
                // NOTE: state updates use <= so every stage samples pre-edge values.
                if (rst) begin
                    a_v <= 1'b0;
                    a_d <= '0;
                    a_e <= 1'b0;
                end else if (flush) begin
                    a_v <= 1'b0;
                end else if (rdy_in) begin
                    a_v <= in_valid;
                    if (in_valid) begin
                        a_d <= seg0_d;
                        a_e <= in_encrypt;
                    end
                end
            end
            assign rdy_in = !a_v || rdy_a;
        end else begin : g_wire0
            assign a_v    = in_valid;
            assign a_d    = seg0_d;
            assign a_e    = in_encrypt;
            assign rdy_in = rdy_a;
        end

        if (STAGES >= 3) begin : g_reg1
            always_ff @(posedge clk) begin
                if (rst) begin
                    b_v <= 1'b0;
                    b_d <= '0;
                    b_e <= 1'b0;
                end else if (flush) begin
                    b_v <= 1'b0;
                end else if (rdy_a) begin
                    b_v <= a_v;
                    if (a_v) begin
                        b_d <= seg1_d;
                        b_e <= a_e;
                    end
                end
            end
            assign rdy_a = !b_v || rdy_b;
        end else begin : g_wire1
            assign b_v   = a_v;
            assign b_d   = seg1_d;
            assign b_e   = a_e;
            assign rdy_a = rdy_b;
        end
    endgenerate

    // Payload only moves on a load, so a stalled output holds its data and mode bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_encrypt <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (rdy_b) begin
            out_valid <= b_v;
            if (b_v) begin
                out_data    <= seg2_d;
                out_encrypt <= b_e;
            end
        end
    end

    assign rdy_b    = !out_valid || out_ready;
    assign in_ready = !flush && rdy_in;

`ifdef SBOX_PIPE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            xfer_count <= '0;
        else if (out_valid && out_ready && (xfer_count != 32'hFFFF_FFFF))
            xfer_count <= xfer_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sbox_pprm_pipe.sv
// Scoreboard bench for sbox_pprm_pipe: expected bytes come from the published AES S-box table.
// Build with SBOX_PIPE_CNT_EN defined to also check xfer_count.
module tb_sbox_pprm_pipe;
    localparam int LANES  = 4;
    localparam int STAGES = 3;
    localparam int W      = 8 * LANES;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, in_encrypt;
    logic         out_valid, out_ready, out_encrypt;
    logic [W-1:0] in_data, out_data;
`ifdef SBOX_PIPE_CNT_EN
    logic [31:0]  xfer_count;
`endif

    always #5 clk = ~clk;

    sbox_pprm_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_encrypt (in_encrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_encrypt(out_encrypt)
`ifdef SBOX_PIPE_CNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] isbox [256];

    logic [W:0] sb_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_fired  = 0;
    int n_stray  = 0;
    int cnt_model = 0;
    logic acc, fired;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        int idx;
        row = sbox_rows[b[7:4]];
        idx = 8 * (15 - int'(b[3:0]));
        return row[idx +: 8];
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic e);
        logic [W-1:0] r;
        for (int j = 0; j < LANES; j++)
            r[8*j +: 8] = e ? sbox(d[8*j +: 8]) : isbox[d[8*j +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, sample handshakes 1ns later, then advance past the next edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic e, input logic ordy,
                         output logic acc_o, output logic fired_o);
        logic [W:0] exp;
        in_valid   = v;
        in_data    = d;
        in_encrypt = e;
        out_ready  = ordy;
        #1;
        acc_o   = v && in_ready;
        fired_o = out_valid && ordy;
        if (fired_o) begin
            n_fired++;
            cnt_model++;
            if (sb_q.size() == 0) begin
                n_stray++;
            end else begin
                exp = sb_q.pop_front();
                check("out_xfer", 64'({out_encrypt, out_data}), 64'(exp));
            end
        end
        if (acc_o) sb_q.push_back({e, model(d, e)});
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (sb_q.size() > 0 && guard < 100) begin
            cycle(1'b0, '0, 1'b0, 1'b1, acc, fired);
            guard++;
        end
        check(tag, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic latency_test(input logic [W-1:0] d, input logic e, input logic [W-1:0] exp_data);
        int lat;
        cycle(1'b1, d, e, 1'b0, acc, fired);
        check("lat_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
        end
        check("latency", 64'(lat), 64'(STAGES));
        check("lat_data", 64'({out_encrypt, out_data}), 64'({e, exp_data}));
        drain("lat_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, accepted, unstable;
        logic have;
        logic [W:0] held;
        logic [W-1:0] d;
`ifdef SBOX_PIPE_CNT_EN
        logic [31:0] cnt_before;
`endif
        for (int b = 0; b < 256; b++) isbox[sbox(8'(b))] = 8'(b);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_encrypt = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_encrypt", 64'(out_encrypt), 64'd0);
`ifdef SBOX_PIPE_CNT_EN
        check("rst_count", 64'(xfer_count), 64'd0);
`endif
        rst = 1'b0;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        latency_test(32'hFF01_5300, 1'b1, 32'h167C_ED63);
        latency_test(32'h167C_ED63, 1'b0, 32'hFF01_5300);

        // Alternating modes, every byte value in both directions, no stalls.
        f0 = n_fired;
        accepted = 0;
        for (int k = 0; k < 128; k++) begin
            for (int j = 0; j < LANES; j++) d[8*j +: 8] = 8'(4 * (k >> 1) + j);
            cycle(1'b1, d, (k % 2) == 0, 1'b1, acc, fired);
            if (acc) accepted++;
        end
        check("stream_accepts", 64'(accepted), 64'd128);
        check("stream_fires", 64'(n_fired - f0), 64'(128 - STAGES));
        drain("stream_drain");
        check("stream_total", 64'(n_fired - f0), 64'd128);

        // Backpressure: out_ready low for 10 cycles while offering input every cycle.
        f0 = n_fired;
        accepted = 0;
        unstable = 0;
        have = 1'b0;
        held = '0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc, fired);
            if (acc) accepted++;
            if (out_valid) begin
                if (!have) begin
                    held = {out_encrypt, out_data};
                    have = 1'b1;
                end else if ({out_encrypt, out_data} !== held) begin
                    unstable++;
                end
            end
        end
        check("bp_accepts", 64'(accepted), 64'(STAGES));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_stable", 64'(unstable), 64'd0);
        drain("bp_drain");
        check("bp_released", 64'(n_fired - f0), 64'(STAGES));

        // Flush a full pipeline while input is offered.
        for (int c = 0; c < 5; c++) cycle(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc, fired);
`ifdef SBOX_PIPE_CNT_EN
        cnt_before = xfer_count;
`endif
        flush = 1'b1; in_valid = 1'b1; in_data = W'($urandom); out_ready = 1'b0;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
`ifdef SBOX_PIPE_CNT_EN
        check("flush_count", 64'(xfer_count), 64'(cnt_before));
`endif
        f0 = n_fired;
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, acc, fired);
        check("flush_no_stale", 64'(n_fired - f0), 64'd0);

        // Reset for one cycle in the middle of a stream.
        for (int c = 0; c < 4; c++) cycle(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b1, acc, fired);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 1'b0;
        sb_q.delete();
        cnt_model = 0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
`ifdef SBOX_PIPE_CNT_EN
        check("mid_rst_count", 64'(xfer_count), 64'd0);
`endif
        latency_test(32'h0001_0203, 1'b1, 32'h637C_777B);

`ifdef SBOX_PIPE_CNT_EN
        check("final_count", 64'(xfer_count), 64'(cnt_model));
`endif
        check("no_stray_outputs", 64'(n_stray), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sbox_pprm_pipe.md
# sbox_pprm_pipe

Pipelined, multi-lane AES S-box unit built on the 3-stage PPRM inverter datapath. It substitutes LANES bytes per transfer in either direction, with forward (encrypt) or inverse (decrypt) S-box chosen per transfer. The unit sits between the round-key/state datapath and the ShiftRows/MixColumns logic and replaces the single-byte combinational S-box where throughput and timing closure require registered stages. It exchanges data with both neighbours over valid/ready handshakes with full backpressure.

## Interface
- LANES, 4, number of byte lanes substituted in parallel (1..16)
- STAGES, 3, pipeline register stages (1..3), which also sets the latency in cycles
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all in-flight transfers
- in_valid  input  1  input transfer offered
- in_ready  output  1  unit accepts the input transfer this cycle
- in_data  input  8*LANES  bytes to substitute; lane i = bits [8i+7:8i]
- in_encrypt  input  1  1 = forward S-box, 0 = inverse S-box; travels with the transfer
- out_valid  output  1  result transfer offered
- out_ready  input  1  downstream accepts the result
- out_data  output  8*LANES  substituted bytes, same lane mapping as in_data
- out_encrypt  output  1  mode bit of the transfer on out_data
- xfer_count  output  32  completed output transfers (present only with SBOX_PIPE_CNT_EN)

## Operation
- Per lane, encrypt: out = A(inv(x)), where A is the forward affine transform (constant 0x63). Decrypt: out = inv(A⁻¹(x)), where A⁻¹ is the inverse affine transform (constant 0x05). inv is the PPRM GF(2^8) inverse, with inv(0x00) = 0x00.
- All lanes share one mode bit per transfer. Lanes are independent, with no cross-lane carry.
- Datapath segments are input transform (A⁻¹ or pass), inverter, and output transform (A or pass).
- Register placement depends on STAGES:
  - STAGES=1: one register after the output transform.
  - STAGES=2: registers after the input transform and after the output transform.
  - STAGES=3: registers after each segment.
- Each stage register holds data, the mode bit and a valid bit. The mode bit steers the muxes of later segments, so mixed-mode transfers in flight are legal.
- Handshake:
  - A stage loads when its upstream is valid and it is either empty or unloading this cycle.
  - in_ready = !v0 | advance0, where advance_k = !v_{k+1} | advance_{k+1}, and advance_last = out_ready.
  - in_ready therefore combinationally depends on out_ready. There are no bubbles: with out_ready held at 1, the unit sustains one transfer per cycle.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_encrypt hold unchanged.
- flush: on the next edge, all valid bits clear. Input offered in the flush cycle is dropped, and in_ready is forced to 0 during flush.
- Reset: all valid bits are 0, out_data = 0, out_encrypt = 0, xfer_count = 0. Reset takes priority over flush and over any handshake.

## Timing
- Latency: a transfer accepted at edge n appears with out_valid=1 after edge n+STAGES-1. It is visible in the cycle following edge n+STAGES-1.
- Throughput: 1 transfer/cycle when unstalled.
- Stall: when out_ready=0 with a full pipeline, in_ready=0 in that same cycle.
- Simultaneous events:
  - Accept plus drain in the same cycle on a full pipeline: both occur and occupancy is unchanged.
  - Reset mid-stream: in-flight transfers are discarded and no partial output is emitted.
- Critical path, STAGES=1: full S-box. STAGES=3: inverter segment only.

## Configuration
- SBOX_PIPE_CNT_EN defined:
  - Adds the xfer_count port.
  - xfer_count increments on each out_valid & out_ready edge and saturates at 0xFFFFFFFF.
  - It clears on rst only; flush does not clear it.
- Undefined: the port and the counter are absent, and datapath behaviour is identical.

## Test plan
- Encrypt, LANES=4, in_data=0xFF01_5300 (lanes 3..0 = FF,01,53,00), out_ready=1 -> after STAGES cycles out_data=0x167C_ED63, out_encrypt=1.
- Decrypt, in_data=0x167C_ED63 -> out_data=0xFF01_5300. Exhaustively sweep all 256 bytes in both modes against the reference table; each must round-trip.
- Back-to-back alternating encrypt/decrypt for 64 cycles with out_ready=1 -> 64 outputs in order, each with correct per-transfer mode, no bubbles.
- Backpressure: hold out_ready=0 for 10 cycles while streaming:
  - in_ready drops after STAGES accepts.
  - out_data is stable throughout.
  - After release, all transfers emerge in order, none lost or duplicated.
- flush with a full pipeline and in_valid=1 -> next cycle out_valid=0, no stale data appears, and the flushed input is not accepted. With SBOX_PIPE_CNT_EN, xfer_count is unchanged.
- rst asserted mid-stream for 1 cycle -> out_valid=0, out_data=0, xfer_count=0. The first new transfer after reset emerges with exact STAGES latency.
